// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit ALU datapath and its downstream result/status logic.
package alu_pkg;

    localparam int ALU_WIDTH       = 4;
    localparam int ALU_OPW         = 4;
    localparam int ARITH_CLASS_BIT = 3;

    // Opcodes with bit 3 set belong to the arithmetic class (carry/ovf meaningful)
    localparam logic [ALU_OPW-1:0] OP_AND  = 4'h0;
    localparam logic [ALU_OPW-1:0] OP_NAND = 4'h1;
    localparam logic [ALU_OPW-1:0] OP_OR   = 4'h2;
    localparam logic [ALU_OPW-1:0] OP_NOR  = 4'h3;
    localparam logic [ALU_OPW-1:0] OP_XOR  = 4'h4;
    localparam logic [ALU_OPW-1:0] OP_XNOR = 4'h5;
    localparam logic [ALU_OPW-1:0] OP_PASSA = 4'h6;
    localparam logic [ALU_OPW-1:0] OP_NOTA = 4'h7;
    localparam logic [ALU_OPW-1:0] OP_ADD  = 4'h8;
    localparam logic [ALU_OPW-1:0] OP_ADC  = 4'h9;
    localparam logic [ALU_OPW-1:0] OP_SUB  = 4'hA;
    localparam logic [ALU_OPW-1:0] OP_SBB  = 4'hB;
    localparam logic [ALU_OPW-1:0] OP_INC  = 4'hC;
    localparam logic [ALU_OPW-1:0] OP_DEC  = 4'hD;
    localparam logic [ALU_OPW-1:0] OP_NEG  = 4'hE;
    localparam logic [ALU_OPW-1:0] OP_CMP  = 4'hF;

    typedef struct packed {
        logic zero;
        logic neg;
        logic carry;
        logic ovf;
    } alu_flags_t;

    function automatic logic is_arith(input logic [ALU_OPW-1:0] op);
        return op[ARITH_CLASS_BIT];
    endfunction

endpackage

// File: rtl/alu_flag_gen.sv
// Purpose: derive zero/neg/carry/ovf status from an ALU result and its opcode.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module alu_flag_gen
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int OPW   = ALU_OPW
) (
    input  logic [WIDTH-1:0] result,
    input  logic [OPW-1:0]   op,
    input  logic             carry,
    input  logic             ovf,
    output alu_flags_t       flags
);

    logic arith;
    logic unused_op_bits;

    assign arith          = op[ARITH_CLASS_BIT];
    assign unused_op_bits = ^op;

    // Raw carry/ovf from the arith unit are garbage for logic ops, so mask them here.
    always_comb begin
        flags       = '0;
        flags.zero  = (result == '0);
        flags.neg   = result[WIDTH-1];
        flags.carry = carry & arith;
        flags.ovf   = ovf & arith;
    end

endmodule

// File: rtl/alu_result_stage.sv
// Purpose: register ALU results with derived flags in a 2-entry skid FIFO; sticky ovf and delivered count.
// Latency: one cycle from accept to out_valid when empty.
// Backpressure: in_ready is registered from occupancy only and drops when both entries are held.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int OPW   = ALU_OPW,
    parameter int CNTW  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic [OPW-1:0]   in_op,
    input  logic             in_carry,
    input  logic             in_ovf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [OPW-1:0]   out_op,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_carry,
    output logic             out_ovf,
    output logic             sticky_ovf,
    input  logic             sticky_clr,
    output logic [CNTW-1:0]  result_count
);

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic [OPW-1:0]   op;
        alu_flags_t       flags;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_e;

    localparam logic [CNTW-1:0] CNT_MAX = '1;

    occ_e       state;
    entry_t     head_q;
    entry_t     tail_q;
    entry_t     in_entry;
    alu_flags_t in_flags;
    logic       out_valid_q;
    logic       in_ready_q;
    logic       push;
    logic       pop;

    alu_flag_gen #(
        .WIDTH (WIDTH),
        .OPW   (OPW)
    ) u_flag_gen (
        .result (in_result),
        .op     (in_op),
        .carry  (in_carry),
        .ovf    (in_ovf),
        .flags  (in_flags)
    );

    assign in_entry = '{result: in_result, op: in_op, flags: in_flags};
    assign push     = in_valid & in_ready_q;
    assign pop      = out_valid_q & out_ready;

    // Head slot always drives the outputs; it is zeroed whenever the FIFO drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= EMPTY;
            head_q      <= '0;
            tail_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    in_ready_q <= 1'b1;
                    if (push) begin
                        head_q      <= in_entry;
                        out_valid_q <= 1'b1;
                        state       <= ONE;
                    end
                end
                ONE: begin
                    case ({push, pop})
                        2'b10: begin
                            tail_q     <= in_entry;
                            in_ready_q <= 1'b0;
                            state      <= FULL;
                        end
                        2'b01: begin
                            head_q      <= '0;
                            out_valid_q <= 1'b0;
                            state       <= EMPTY;
                        end
                        2'b11: begin
                            head_q <= in_entry;
                        end
                        default: begin
                            head_q <= head_q;
                        end
                    endcase
                end
                FULL: begin
                    if (pop) begin
                        head_q     <= tail_q;
                        tail_q     <= '0;
                        in_ready_q <= 1'b1;
                        state      <= ONE;
                    end
                end
                default: begin
                    head_q      <= '0;
                    tail_q      <= '0;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b0;
                    state       <= EMPTY;
                end
            endcase
        end
    end

    // Set has priority over clear so an overflow delivered during a clear is not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_ovf   <= 1'b0;
            result_count <= '0;
        end else begin
            if (pop && head_q.flags.ovf) begin
                sticky_ovf <= 1'b1;
            end else if (sticky_clr) begin
                sticky_ovf <= 1'b0;
            end
            if (pop && (result_count != CNT_MAX)) begin
                result_count <= result_count + 1'b1;
            end
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_result = head_q.result;
    assign out_op     = head_q.op;
    assign out_zero   = head_q.flags.zero;
    assign out_neg    = head_q.flags.neg;
    assign out_carry  = head_q.flags.carry;
    assign out_ovf    = head_q.flags.ovf;

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: expected entries queued at drive time, compared on delivery.
module tb_alu_result_stage;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_result;
    logic [3:0] in_op;
    logic       in_carry;
    logic       in_ovf;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_result;
    logic [3:0] out_op;
    logic       out_zero;
    logic       out_neg;
    logic       out_carry;
    logic       out_ovf;
    logic       sticky_ovf;
    logic       sticky_clr;
    logic [7:0] result_count;

    typedef struct packed {
        logic [3:0] res;
        logic [3:0] op;
        logic       z;
        logic       n;
        logic       c;
        logic       v;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   tests_run;
    int   tests_failed;

    wire [11:0] obs = {out_result, out_op, out_zero, out_neg, out_carry, out_ovf};

    alu_result_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_result    (in_result),
        .in_op        (in_op),
        .in_carry     (in_carry),
        .in_ovf       (in_ovf),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_op       (out_op),
        .out_zero     (out_zero),
        .out_neg      (out_neg),
        .out_carry    (out_carry),
        .out_ovf      (out_ovf),
        .sticky_ovf   (sticky_ovf),
        .sticky_clr   (sticky_clr),
        .result_count (result_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [3:0] res, input logic [3:0] op,
                                input logic c, input logic v);
        exp_t x;
        x.res = res;
        x.op  = op;
        x.z   = (res == 4'h0);
        x.n   = res[3];
        x.c   = op[3] ? c : 1'b0;
        x.v   = op[3] ? v : 1'b0;
        return x;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] res, input logic [3:0] op,
                         input logic c, input logic v);
        in_valid  = 1'b1;
        in_result = res;
        in_op     = op;
        in_carry  = c;
        in_ovf    = v;
        sb.push_back(mk(res, op, c, v));
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({out_valid, in_ready, sticky_ovf, result_count, obs} !== 23'd0) begin
            tests_failed++;
            $display("FAIL reset_state: valid=%0b rdy=%0b sticky=%0b cnt=%0d head=%h, required all 0",
                     out_valid, in_ready, sticky_ovf, result_count, obs);
        end
        rst_n = 1'b1;
        cyc();
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_release_ready: in_ready=%0b, required 1", in_ready);
        end
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        drive(4'h0, 4'b1000, 1'b1, 1'b0);
        cyc();
        in_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b1 || sb.size() == 0) begin
            tests_failed++;
            $display("FAIL single_latency: out_valid=%0b, required 1", out_valid);
        end else begin
            e = sb.pop_front();
            tests_run++;
            if (obs !== e) begin
                tests_failed++;
                $display("FAIL single_data: got %h, required %h", obs, e);
            end
        end
        cyc();
        tests_run++;
        if (result_count !== 8'd1 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_count: cnt=%0d valid=%0b, required 1 and 0", result_count, out_valid);
        end
    endtask

    task automatic test_logic_flags();
        out_ready = 1'b1;
        drive(4'h9, 4'b0010, 1'b1, 1'b1);
        cyc();
        in_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b1 || sb.size() == 0) begin
            tests_failed++;
            $display("FAIL logic_valid: out_valid=%0b, required 1", out_valid);
        end else begin
            e = sb.pop_front();
            tests_run++;
            if (obs !== e) begin
                tests_failed++;
                $display("FAIL logic_flags: got %h, required %h", obs, e);
            end
        end
        cyc();
        tests_run++;
        if (sticky_ovf !== 1'b0) begin
            tests_failed++;
            $display("FAIL logic_sticky: sticky_ovf=%0b, required 0", sticky_ovf);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(4'h3, 4'b0001, 1'b0, 1'b0);
        cyc();
        drive(4'h5, 4'b1001, 1'b1, 1'b0);
        cyc();
        tests_run++;
        if (in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_full_ready: in_ready=%0b, required 0", in_ready);
        end
        in_valid  = 1'b1;
        in_result = 4'h7;
        in_op     = 4'b1111;
        repeat (2) cyc();
        in_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b1 || out_result !== 4'h3 || in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_hold: valid=%0b result=%h rdy=%0b, required 1 3 0",
                     out_valid, out_result, in_ready);
        end
        cyc();
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            tests_run++;
            if (out_valid !== 1'b1 || sb.size() == 0) begin
                tests_failed++;
                $display("FAIL bp_drain_valid: beat %0d out_valid=%0b, required 1", k, out_valid);
            end else begin
                e = sb.pop_front();
                tests_run++;
                if (obs !== e) begin
                    tests_failed++;
                    $display("FAIL bp_drain_data: beat %0d got %h, required %h", k, obs, e);
                end
            end
            cyc();
        end
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_drained: valid=%0b rdy=%0b, required 0 1 (ignored push leaked?)",
                     out_valid, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            if (i <= 8) drive(4'(i), 4'b0100, 1'b0, 1'b0);
            else in_valid = 1'b0;
            @(negedge clk);
            if (i > 1) begin
                tests_run++;
                if (out_valid !== 1'b1 || in_ready !== 1'b1 || sb.size() == 0) begin
                    tests_failed++;
                    $display("FAIL b2b_flow: step %0d valid=%0b rdy=%0b, required 1 1", i, out_valid, in_ready);
                end else begin
                    e = sb.pop_front();
                    tests_run++;
                    if (obs !== e) begin
                        tests_failed++;
                        $display("FAIL b2b_data: step %0d got %h, required %h", i, obs, e);
                    end
                end
            end
            cyc();
        end
    endtask

    task automatic test_sticky();
        out_ready = 1'b0;
        drive(4'h8, 4'b1000, 1'b0, 1'b1);
        cyc();
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        sticky_clr = 1'b1;
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b1 || sb.size() == 0) begin
            tests_failed++;
            $display("FAIL sticky_valid: out_valid=%0b, required 1", out_valid);
        end else begin
            e = sb.pop_front();
            tests_run++;
            if (obs !== e) begin
                tests_failed++;
                $display("FAIL sticky_data: got %h, required %h", obs, e);
            end
        end
        cyc();
        out_ready = 1'b0;
        tests_run++;
        if (sticky_ovf !== 1'b1) begin
            tests_failed++;
            $display("FAIL sticky_set_wins: sticky_ovf=%0b, required 1", sticky_ovf);
        end
        cyc();
        sticky_clr = 1'b0;
        tests_run++;
        if (sticky_ovf !== 1'b0) begin
            tests_failed++;
            $display("FAIL sticky_clear: sticky_ovf=%0b, required 0", sticky_ovf);
        end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b1;
        drive(4'h2, 4'b1010, 1'b0, 1'b1);
        cyc();
        in_valid = 1'b0;
        @(negedge clk);
        void'(sb.pop_front());
        cyc();
        tests_run++;
        if (sticky_ovf !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_precond_sticky: sticky_ovf=%0b, required 1", sticky_ovf);
        end
        out_ready = 1'b0;
        drive(4'hA, 4'b0101, 1'b0, 1'b0);
        cyc();
        drive(4'hB, 4'b0110, 1'b0, 1'b0);
        cyc();
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        sb.delete();
        tests_run++;
        if ({out_valid, in_ready, sticky_ovf, result_count, obs} !== 23'd0) begin
            tests_failed++;
            $display("FAIL mid_reset_async: valid=%0b rdy=%0b sticky=%0b cnt=%0d head=%h, required all 0",
                     out_valid, in_ready, sticky_ovf, result_count, obs);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        out_ready = 1'b1;
        drive(4'h6, 4'b0011, 1'b1, 1'b1);
        cyc();
        in_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b1 || sb.size() == 0) begin
            tests_failed++;
            $display("FAIL mid_fresh_valid: out_valid=%0b, required 1", out_valid);
        end else begin
            e = sb.pop_front();
            tests_run++;
            if (obs !== e) begin
                tests_failed++;
                $display("FAIL mid_fresh_data: got %h, required %h", obs, e);
            end
        end
        cyc();
        tests_run++;
        if (out_valid !== 1'b0 || result_count !== 8'd1) begin
            tests_failed++;
            $display("FAIL mid_no_stale: valid=%0b cnt=%0d, required 0 1", out_valid, result_count);
        end
    endtask

    task automatic test_saturation();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        out_ready = 1'b1;
        in_op     = 4'b0000;
        in_carry  = 1'b0;
        in_ovf    = 1'b0;
        for (int i = 0; i < 254; i++) begin
            in_valid  = 1'b1;
            in_result = 4'(i);
            cyc();
        end
        in_valid = 1'b0;
        cyc();
        @(negedge clk);
        tests_run++;
        if (result_count !== 8'd254) begin
            tests_failed++;
            $display("FAIL sat_preload: cnt=%0d, required 254", result_count);
        end
        for (int k = 0; k < 3; k++) begin
            in_valid  = 1'b1;
            in_result = 4'h1;
            cyc();
            in_valid = 1'b0;
            cyc();
            @(negedge clk);
            tests_run++;
            if (result_count !== 8'd255) begin
                tests_failed++;
                $display("FAIL sat_count: pop %0d cnt=%0d, required 255", k, result_count);
            end
        end
        tests_run++;
        if (sb.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_empty: %0d entries undelivered, required 0", sb.size());
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        in_valid     = 1'b0;
        in_result    = 4'h0;
        in_op        = 4'h0;
        in_carry     = 1'b0;
        in_ovf       = 1'b0;
        out_ready    = 1'b0;
        sticky_clr   = 1'b0;
        rst_n        = 1'b0;
        test_reset();
        test_single();
        test_logic_flags();
        test_backpressure();
        test_back_to_back();
        test_sticky();
        test_reset_midstream();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Registered output stage directly downstream of the 4-bit 16-function ALU datapath (the and/or/xor/arith function units and the result mux).
- Captures each ALU result together with its opcode and raw carry/overflow, and derives status flags.
- Buffers results in a 2-entry skid FIFO behind a valid/ready handshake, so the ALU never has to stall mid-operation.
- Keeps a sticky overflow flag and a saturating count of delivered results.

Parameters:
- WIDTH, 4, result/operand width in bits; flags are derived from bit WIDTH-1.
- OPW, 4, opcode width (16 functions).
- CNTW, 8, width of the delivered-result counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  ALU result valid.
- in_ready  output  1  stage can accept a result.
- in_result  input  WIDTH  ALU result.
- in_op  input  OPW  opcode that produced in_result.
- in_carry  input  1  raw carry-out from the arithmetic unit.
- in_ovf  input  1  raw signed overflow from the arithmetic unit.
- out_valid  output  1  head entry valid.
- out_ready  input  1  consumer accepts the head entry.
- out_result  output  WIDTH  head result.
- out_op  output  OPW  head opcode.
- out_zero  output  1  head result == 0.
- out_neg  output  1  head result bit WIDTH-1.
- out_carry  output  1  head carry, masked.
- out_ovf  output  1  head overflow, masked.
- sticky_ovf  output  1  set once any delivered result had out_ovf=1.
- sticky_clr  input  1  synchronous clear of sticky_ovf.
- result_count  output  CNTW  saturating count of delivered results.

Behaviour:
- Reset (async assert, sync release): FIFO empty, all out_* = 0, in_ready = 0 during reset, sticky_ovf = 0, result_count = 0.
- in_ready = (occupancy < 2) while out of reset; it is registered and derived from occupancy only, never from out_ready.
- Push when in_valid & in_ready; pop when out_valid & out_ready.
- Flags are computed at push time and stored with the entry, so there is no combinational path from in_* to out_*:
  - zero = (in_result == 0).
  - neg = in_result[WIDTH-1].
  - carry/ovf pass through only for the arithmetic class, in_op[3] == 1; otherwise both are stored as 0.
- Occupancy FSM:
  - EMPTY: push -> ONE.
  - ONE: push without pop -> FULL; pop without push -> EMPTY; push with pop -> ONE, and the new entry becomes head next cycle.
  - FULL: in_ready = 0, no push possible; pop -> ONE, and the second entry moves to head.
- Latency: a result accepted in cycle N appears on out_* with out_valid = 1 in cycle N+1 when the FIFO was EMPTY.
- Ordering: strict FIFO; entries are never dropped or duplicated.
- out_* hold stable while out_valid & !out_ready.
- Head fields are don't-care when out_valid = 0, but the RTL drives them to 0.
- sticky_ovf:
  - Set on a pop with out_ovf = 1.
  - Cleared by sticky_clr.
  - If a set and a clear occur in the same cycle, the set wins.
- result_count: increments on each pop and saturates at 2^CNTW-1 (no wrap).
- Reset asserted mid-operation: all buffered entries are discarded immediately; outputs go to their reset values asynchronously.
- Data is stored at capture, so in_* changes while in_ready = 0 have no effect.

Decomposition:
- Shared package alu_pkg:
  - WIDTH/OPW defaults.
  - Opcode constants for the 16 functions.
  - ARITH_CLASS_BIT = 3.
  - Flag bundle typedef {zero, neg, carry, ovf}.
- One sub-module, alu_flag_gen: a combinational flag derivation from result and op. It is reused later by the ALU status register.
- FIFO storage and the FSM stay in alu_result_stage.

Test Plan:
- Single push, op=4'b1000, result=4'h0, carry=1, ovf=0, out_ready=1 -> next cycle out_valid=1, out_result=0, zero=1, neg=0, carry=1; result_count=1 after the pop.
- Logic op 4'b0010 with in_carry=1, in_ovf=1, result=4'h9 -> out_carry=0, out_ovf=0, out_neg=1, sticky_ovf stays 0.
- out_ready=0 with pushes of 4'h3, 4'h5 -> in_ready=0 after the 2nd push, a 3rd in_valid is ignored; releasing out_ready delivers 3 then 5 in consecutive cycles.
- Steady streaming in ONE state with simultaneous push/pop every cycle, results 1..8 -> delivered 1..8 in order, one per cycle, in_ready stays 1.
- Arithmetic op with ovf=1 delivered while sticky_clr=1 in the same cycle -> sticky_ovf=1; sticky_clr alone the next cycle -> 0.
- Two entries buffered, assert rst_n=0 mid-stream -> out_valid=0, counter=0, sticky=0 immediately; after release the first push is delivered with no stale data.
- Force result_count to 254, then three pops -> 255, 255, 255.
